// File: rtl/slice_serial_alu_seq_pkg.sv
// Shared definitions for the slice-serial ADD/XOR controller.
// Holds the op encoding, the FSM state encoding and the operand/slice width rule.
// The controller calls width_ok() at elaboration and stops with an error if it fails.
package slice_serial_alu_seq_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_XOR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The operand must split into a whole number of slices.
  function automatic bit width_ok(int data_w, int slice_w);
    return (slice_w > 0) && (data_w >= slice_w) && ((data_w % slice_w) == 0);
  endfunction

endpackage

// File: rtl/slice_serial_alu_seq_if.sv
// Command and result handshake bundle for the slice-serial ALU.
// No logic and no latency; it only groups the signals.
// Both directions use valid/ready: in_valid/in_ready for commands, out_valid/out_ready for results.
interface slice_serial_alu_seq_if #(
  parameter int DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic              op;
  logic              carry_in;
  logic [0:DATA_W-1] operand_a;
  logic [0:DATA_W-1] operand_b;
  logic              out_valid;
  logic              out_ready;
  logic [0:DATA_W-1] result;
  logic              carry_out;
  logic              busy;

  modport slave (
    input  in_valid, op, carry_in, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, carry_out, busy
  );

  modport master (
    output in_valid, op, carry_in, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, carry_out, busy
  );
endinterface

// File: rtl/slice_serial_alu_seq_slice_alu.sv
// Narrow combinational ADD/XOR slice with carry in and carry out.
// Purely combinational, so it adds no cycles of latency.
// It has no handshake; the controller decides when its outputs are used.
module slice_alu
  import slice_serial_alu_seq_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  input  logic               op,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] add_full;

  assign add_full = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  // XOR never propagates a carry into the next slice.
  assign {cout, sum} = (op == OP_XOR) ? {1'b0, a ^ b} : add_full;

endmodule

// File: rtl/slice_serial_alu_seq.sv
// DATA_W-bit ADD or XOR run through one SLICE_W-bit slice ALU, least-significant slice first.
// out_valid rises NUM_SLICES cycles after the accept edge; the minimum command period is NUM_SLICES+2 cycles.
// in_ready is high only in IDLE; the result is held in DONE until out_ready is high.
module slice_serial_alu_seq
  import slice_serial_alu_seq_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int SLICE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  slice_serial_alu_seq_if.slave bus
);

  localparam int NUM_SLICES = DATA_W / SLICE_W;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int BASE_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  if (!width_ok(DATA_W, SLICE_W)) begin : g_width_err
    $error("DATA_W must be a positive integer multiple of SLICE_W");
  end

  state_t            state_q, state_d;
  logic [0:DATA_W-1] a_q, a_d, b_q, b_d, result_q, result_d;
  logic              op_q, op_d, carry_q, carry_d, cout_q, cout_d;
  logic [IDX_W-1:0]  idx_q, idx_d;

  logic [BASE_W-1:0]  base;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic               sl_cout;

  // Slice k sits at the low-order end of the index-0-is-MSB vectors, so slice 0 is the LSB slice.
  assign base = BASE_W'(DATA_W - SLICE_W * (int'(idx_q) + 1));
  assign sl_a = a_q[base +: SLICE_W];
  assign sl_b = b_q[base +: SLICE_W];

  slice_alu #(.SLICE_W(SLICE_W)) u_slice_alu (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .op   (op_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.carry_out = cout_q;

  // Next state: latch the command on accept, process one slice per cycle, then hold until the result is taken.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.operand_a;
          b_d     = bus.operand_b;
          op_d    = bus.op;
          carry_d = (bus.op == OP_ADD) ? bus.carry_in : 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        result_d[base +: SLICE_W] = sl_sum;
        carry_d = sl_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = sl_cout;
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

endmodule

// File: tb/tb_slice_serial_alu_seq.sv
// Scoreboard bench for slice_serial_alu_seq using directed vectors with hand-computed results.
// The driver pushes expected results into a queue; a monitor pops one on every result handshake.
// It also checks reset values, latency, command period, backpressure hold and asynchronous reset.
module tb_slice_serial_alu_seq;
  import slice_serial_alu_seq_pkg::*;

  typedef struct {
    logic [0:15] r;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc;
  exp_t exp_q[$];

  slice_serial_alu_seq_if #(.DATA_W(16)) bus ();

  slice_serial_alu_seq #(.DATA_W(16), .SLICE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every result handshake is compared with the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h with an empty scoreboard", bus.result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", 32'(bus.result), 32'(e.r));
        chk("carry_out", 32'(bus.carry_out), 32'(e.c));
      end
    end
  end

  // Issue one command. On return the accept edge is past and the inputs have been scrambled,
  // so the result can only be right if the DUT latched them at accept.
  task automatic send(input logic op, input logic cin, input logic [0:15] a, input logic [0:15] b,
                      input logic [0:15] er, input logic ec, input bit push);
    int n;
    exp_t e;
    bus.op        = op;
    bus.carry_in  = cin;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.in_valid  = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    if (push) begin
      e.r = er;
      e.c = ec;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.op        = ~op;
    bus.carry_in  = ~cin;
    bus.operand_a = 16'($urandom);
    bus.operand_b = 16'($urandom);
  endtask

  task automatic wait_out_valid();
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    int lat;
    int first_acc;
    int n;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.carry_in  = 1'b0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.out_ready = 1'b1;
    #3;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_carry_out", 32'(bus.carry_out), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: full carry ripple, latency and busy
    send(OP_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1);
    chk("lat_out_valid_low", 32'(bus.out_valid), 32'd0);
    chk("lat_busy", 32'(bus.busy), 32'd1);
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      lat++;
      chk("lat_busy", 32'(bus.busy), 32'd1);
    end
    chk("latency", 32'(lat), 32'd4);
    @(negedge clk);

    // 2: XOR ignores carry_in
    send(OP_XOR, 1'b1, 16'hA38C, 16'h6390, 16'hC01C, 1'b0, 1'b1);
    wait_out_valid();
    @(negedge clk);

    // 3: slice-boundary carries, back to back to check the command period
    send(OP_ADD, 1'b0, 16'h000F, 16'h0001, 16'h0010, 1'b0, 1'b1);
    first_acc = acc_cyc;
    send(OP_ADD, 1'b1, 16'h0007, 16'h0001, 16'h0009, 1'b0, 1'b1);
    chk("cmd_period", 32'(acc_cyc - first_acc), 32'd6);
    send(OP_ADD, 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    wait_out_valid();
    @(negedge clk);

    // 4: backpressure holds the result and blocks the next command
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(OP_ADD, 1'b0, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1);
    wait_out_valid();
    bus.in_valid  = 1'b1;
    bus.op        = OP_XOR;
    bus.operand_a = 16'hFFFF;
    bus.operand_b = 16'h0F0F;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_result", 32'(bus.result), 32'h0000);
      chk("bp_carry_out", 32'(bus.carry_out), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(OP_XOR, 1'b0, 16'hFFFF, 16'h0F0F, 16'hF0F0, 1'b0, 1'b1);
    wait_out_valid();
    @(negedge clk);

    // 5: asynchronous reset in the middle of a run
    send(OP_ADD, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_result", 32'(bus.result), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(OP_ADD, 1'b0, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b1);
    wait_out_valid();
    @(negedge clk);

    // 6: inputs change right after accept (send scrambles them); result uses latched values
    send(OP_ADD, 1'b1, 16'h1357, 16'h2468, 16'h37C0, 1'b0, 1'b1);
    wait_out_valid();
    @(negedge clk);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
